// File: rtl/scan_crypto_pkg.sv
// Shared types and default geometry for the encrypted-scan sequencer.
// The state encodings double as the debug phase code seen on the phase output.
package scan_crypto_pkg;

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned CHAIN_LEN  = 128;
    localparam int unsigned KEY_CYCLES = 11;
    localparam int unsigned AES_LAT    = 11;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_KRST   = 4'd1,
        ST_KSTART = 4'd2,
        ST_KWAIT  = 4'd3,
        ST_LOAD   = 4'd4,
        ST_DEC    = 4'd5,
        ST_SHIFT  = 4'd6,
        ST_CAP    = 4'd7,
        ST_UPD    = 4'd8,
        ST_ENC    = 4'd9,
        ST_UNLOAD = 4'd10,
        ST_DONE   = 4'd11
    } state_e;

    // Terminal count for a state that must last n cycles.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/scan_crypto_seq.sv
// Phase sequencer for the encrypted-scan datapath: key expansion, decrypt,
// scan shift/capture/update, encrypt and unload, one pattern per req.
module scan_crypto_seq
    import scan_crypto_pkg::*;
(
    input  logic       tck,
    input  logic       reset_n,
    input  logic       req,
    input  logic       rekey,
    input  logic       abort,
    output logic       ack,
    output logic       busy,
    output logic [3:0] phase,
    output logic       reset_n_ka,
    output logic       start,
    output logic       en,
    output logic       shift_en,
    output logic       capture_en,
    output logic       update_en
);

    localparam logic [CNT_W-1:0] KEY_LAST   = last_cnt(KEY_CYCLES);
    localparam logic [CNT_W-1:0] BLOCK_LAST = last_cnt(BLOCK_W);
    localparam logic [CNT_W-1:0] AES_LAST   = last_cnt(AES_LAT);
    localparam logic [CNT_W-1:0] CHAIN_LAST = last_cnt(CHAIN_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ok_q, key_ok_d;

    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic [3:0] phase_q, phase_d;
    logic       reset_n_ka_q, reset_n_ka_d;
    logic       start_q, start_d;
    logic       en_q, en_d;
    logic       shift_en_q, shift_en_d;
    logic       capture_en_q, capture_en_d;
    logic       update_en_q, update_en_d;

    // req is taken only in IDLE (a req while busy is dropped, not queued);
    // ack is a single-cycle completion pulse, suppressed by an abort before DONE.
    always_comb begin : next_state
        state_d  = state_q;
        key_ok_d = key_ok_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = (rekey || !key_ok_q) ? ST_KRST : ST_LOAD;
            ST_KRST:   state_d = ST_KSTART;
            ST_KSTART: state_d = ST_KWAIT;
            ST_KWAIT: begin
                if (cnt_q == KEY_LAST) begin
                    state_d  = ST_LOAD;
                    key_ok_d = 1'b1;
                end
            end
            ST_LOAD:   if (cnt_q == BLOCK_LAST) state_d = ST_DEC;
            ST_DEC:    if (cnt_q == AES_LAST)   state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CHAIN_LAST) state_d = ST_CAP;
            ST_CAP:    state_d = ST_UPD;
            ST_UPD:    state_d = ST_ENC;
            ST_ENC:    if (cnt_q == AES_LAST)   state_d = ST_UNLOAD;
            ST_UNLOAD: if (cnt_q == BLOCK_LAST) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Abort beats every transition; keys half-built are not trusted afterwards.
        if (abort) begin
            if (state_q == ST_KRST || state_q == ST_KSTART || state_q == ST_KWAIT) begin
                key_ok_d = 1'b0;
            end
            state_d = ST_IDLE;
        end
        if (state_q == ST_IDLE && state_d == ST_KRST) begin
            key_ok_d = 1'b0;
        end

        cnt_d = (state_d == state_q && state_q != ST_IDLE) ? cnt_q + 1'b1 : '0;
    end

    always_comb begin : out_decode
        ack_d        = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        phase_d      = state_d;
        reset_n_ka_d = (state_d == ST_IDLE) ? key_ok_d : (state_d != ST_KRST);
        start_d      = (state_d == ST_KSTART);
        en_d         = (state_d == ST_LOAD) || (state_d == ST_DEC) ||
                       (state_d == ST_ENC)  || (state_d == ST_UNLOAD);
        shift_en_d   = (state_d == ST_SHIFT);
        capture_en_d = (state_d == ST_CAP);
        update_en_d  = (state_d == ST_UPD);
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_ok_q     <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            phase_q      <= 4'd0;
            reset_n_ka_q <= 1'b0;
            start_q      <= 1'b0;
            en_q         <= 1'b0;
            shift_en_q   <= 1'b0;
            capture_en_q <= 1'b0;
            update_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_ok_q     <= key_ok_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            phase_q      <= phase_d;
            reset_n_ka_q <= reset_n_ka_d;
            start_q      <= start_d;
            en_q         <= en_d;
            shift_en_q   <= shift_en_d;
            capture_en_q <= capture_en_d;
            update_en_q  <= update_en_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign phase      = phase_q;
    assign reset_n_ka = reset_n_ka_q;
    assign start      = start_q;
    assign en         = en_q;
    assign shift_en   = shift_en_q;
    assign capture_en = capture_en_q;
    assign update_en  = update_en_q;

endmodule

// File: doc/scan_crypto_seq.md
Name: scan_crypto_seq

Overview:
- Sequencer for the encrypted-scan datapath: decrypt core, then scan chain, then encrypt core.
- Drives reset_n_ka, start, en, shift_en, capture_en and update_en, so each test pattern runs as one deterministic phase sequence: key expansion, ciphertext load, decrypt, chain shift, capture/update, encrypt, ciphertext unload.
- Sits between the test-access controller (req/ack handshake) and the datapath.
- Clocked on tck.

Parameters:
- BLOCK_W, 128, bits per cipher block shifted serially in on TDI and out on TDO
- CHAIN_LEN, 128, scan-chain length in shift cycles
- KEY_CYCLES, 11, cycles from start pulse to round keys valid
- AES_LAT, 11, decrypt/encrypt core latency in cycles
- CNT_W, 8, phase counter width; must satisfy 2^CNT_W > max(BLOCK_W, CHAIN_LEN, KEY_CYCLES, AES_LAT)

Ports:
- tck  in  1  test clock; only clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  run one pattern; sampled in IDLE only
- rekey  in  1  force key expansion on this run; sampled with req
- abort  in  1  synchronous abort; returns to IDLE next cycle
- ack  out  1  one-cycle pulse on pattern completion
- busy  out  1  high in every state except IDLE
- phase  out  4  current state encoding, for debug
- reset_n_ka  out  1  key-expansion reset, active-low
- start  out  1  key-expansion start pulse
- en  out  1  crypto datapath enable
- shift_en, capture_en, update_en  out  1 each  scan chain controls

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, key_ok=0.
  - All outputs 0, including reset_n_ka=0 (key logic held in reset) and phase=0.
- All outputs are registered from state/counter; no combinational path from inputs to outputs.
- States (phase code) and transitions:
  - IDLE(0): on req=1, go to KRST if rekey=1 or key_ok=0, else LOAD. When key_ok=1, IDLE holds reset_n_ka=1.
  - KRST(1): reset_n_ka=0 for exactly 1 cycle, then KSTART.
  - KSTART(2): reset_n_ka=1, start=1 for 1 cycle, then KWAIT.
  - KWAIT(3): reset_n_ka=1; waits KEY_CYCLES cycles; sets key_ok=1; then LOAD.
  - LOAD(4): en=1 for BLOCK_W cycles (ciphertext bits 0..BLOCK_W-1 on TDI), then DEC.
  - DEC(5): en=1 for AES_LAT cycles, then SHIFT.
  - SHIFT(6): shift_en=1 for CHAIN_LEN cycles, then CAP.
  - CAP(7): capture_en=1 for 1 cycle, then UPD.
  - UPD(8): update_en=1 for 1 cycle, then ENC.
  - ENC(9): en=1 for AES_LAT cycles, then UNLOAD.
  - UNLOAD(10): en=1 for BLOCK_W cycles, then DONE.
  - DONE(11): ack=1 for 1 cycle, then IDLE.
- Every state from KSTART through DONE holds reset_n_ka=1.
- Counter:
  - Loads 0 on entry to each counted state.
  - Exits when counter==N-1, so a counted state lasts exactly N cycles.
  - Never wraps; a count of N-1 always forces the transition.
- Total latency, req to ack:
  - With key expansion: 1+1+KEY_CYCLES+BLOCK_W+AES_LAT+CHAIN_LEN+2+AES_LAT+BLOCK_W+1 cycles after the req-sampling edge. Defaults give 422.
  - Key expansion skipped: 409.
- shift_en, capture_en and update_en are mutually exclusive in every cycle. start is never high while reset_n_ka=0.
- Abort:
  - abort=1 in any non-IDLE state: next state IDLE, en, shift_en, capture_en and update_en drop next cycle, no ack.
  - If abort hits in KRST, KSTART or KWAIT, key_ok is cleared and reset_n_ka=0.
  - Otherwise key_ok is kept.
  - abort has priority over every transition, including DONE→IDLE (ack is still issued if already in DONE).
- req while busy is ignored, not queued. req and abort both high in IDLE: abort wins and the run does not start.
- Mid-run reset_n assertion: immediate return to reset values. key_ok=0, so the next run re-expands.

Decomposition:
- Shared package scan_crypto_pkg holds:
  - the state enum with the 4-bit encodings above;
  - default constants BLOCK_W, CHAIN_LEN, KEY_CYCLES, AES_LAT.
- Optional sub-module seq_phase_cnt: loadable down-counter with a terminal flag, reused for every counted state.
- FSM and output decode stay in the top module.

Test Plan:
- Reset, then req=1 with rekey=0 (key_ok=0) → reset_n_ka low 1 cycle, start pulse at cycle 2, ack at cycle 422, busy high cycles 1–422.
- Second req immediately after ack → no KRST/KSTART, shift_en high exactly 128 consecutive cycles, ack at cycle 409.
- Phase widths on a default run: shift_en count=128, capture_en=1 cycle, update_en=1 cycle, en-high total=278, no overlap of scan controls.
- abort asserted at cycle 5 of SHIFT → IDLE next cycle, shift_en=0, no ack, key_ok retained (next run ack at 409).
- abort during KWAIT → key_ok cleared; next req re-runs KRST and ack arrives at 422.
- reset_n pulsed low mid-UNLOAD → all outputs 0 asynchronously; next req runs full key expansion.
